// File: rtl/mak8_pkg.sv
// Shared MAK-8 writeback types: register address/data widths and the
// writeback request record carried by the load queue.
package mak8_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 8;
    localparam int NUM_REGS   = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    typedef struct packed {
        reg_addr_t addr;
        data_t     data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
        logic [NUM_REGS-1:0] oh;
        oh       = {NUM_REGS{1'b0}};
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/load producer handshakes, register-file write
// port, scoreboard and status. WB_BYPASS_EN adds the two forwarding ports.
interface wb_arbiter_if import mak8_pkg::*; #(
    parameter int LQ_DEPTH = 4
) ();

    logic                              alu_valid;
    logic                              alu_ready;
    reg_addr_t                         alu_addr;
    data_t                             alu_data;
    logic                              ld_valid;
    logic                              ld_ready;
    reg_addr_t                         ld_addr;
    data_t                             ld_data;
    logic                              wr_en;
    reg_addr_t                         wr_addr;
    data_t                             wr_data;
    logic [NUM_REGS-1:0]               busy;
    logic [$clog2(LQ_DEPTH+1)-1:0]     q_count;
    logic                              waw_err;

`ifdef WB_BYPASS_EN
    reg_addr_t                         byp_addr1;
    reg_addr_t                         byp_addr2;
    logic                              byp_hit1;
    logic                              byp_hit2;
    data_t                             byp_data1;
    data_t                             byp_data2;

    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
               byp_addr1, byp_addr2,
        output alu_ready, ld_ready, wr_en, wr_addr, wr_data, busy, q_count,
               waw_err, byp_hit1, byp_hit2, byp_data1, byp_data2
    );

    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
               byp_addr1, byp_addr2,
        input  alu_ready, ld_ready, wr_en, wr_addr, wr_data, busy, q_count,
               waw_err, byp_hit1, byp_hit2, byp_data1, byp_data2
    );
`else
    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        output alu_ready, ld_ready, wr_en, wr_addr, wr_data, busy, q_count,
               waw_err
    );

    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        input  alu_ready, ld_ready, wr_en, wr_addr, wr_data, busy, q_count,
               waw_err
    );
`endif

endinterface

// File: rtl/wb_load_fifo.sv
// Load queue for the writeback arbiter: circular buffer of wb_req_t with a
// per-slot valid/addr view used for the busy scoreboard and WAW detection.
module wb_load_fifo import mak8_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  wb_req_t                       push_req,
    output wb_req_t                       head_req,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [DEPTH-1:0]              ent_valid,
    output reg_addr_t [DEPTH-1:0]         ent_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_req_t          mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] offs_s [DEPTH];

    // Storage, pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{addr: {REG_ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
            end
        end else begin
            if (push) begin
                mem_r[tail_r] <= push_req;
                tail_r        <= tail_r + PTR_W'(1);
            end else begin
                tail_r        <= tail_r;
            end
            if (pop) begin
                head_r <= head_r + PTR_W'(1);
            end else begin
                head_r <= head_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            offs_s[i]    = PTR_W'(i) - head_r;
            ent_valid[i] = ({1'b0, offs_s[i]} < count_r);
            ent_addr[i]  = mem_r[i].addr;
        end
    end

    assign head_req = mem_r[head_r];
    assign count    = count_r;

endmodule

// File: rtl/wb_arbiter.sv
// MAK-8 writeback arbiter: merges ALU results and load returns onto the single
// register-file write port. Optional forwarding ports under WB_BYPASS_EN.
module wb_arbiter import mak8_pkg::*; #(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    wb_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(LQ_DEPTH+1);
    localparam int SC_W  = $clog2(STARVE_LIMIT+1);

    logic [CNT_W-1:0]       count_s;
    logic [LQ_DEPTH-1:0]    ent_valid_s;
    reg_addr_t [LQ_DEPTH-1:0] ent_addr_s;
    wb_req_t                head_s;
    wb_req_t                push_req_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   q_nonempty_s;
    logic                   starve_hit_s;
    logic                   alu_rdy_s;
    logic                   ld_rdy_s;
    logic                   alu_fire_s;
    logic                   ld_fire_s;
    logic                   ld_keep_s;
    logic                   nxt_en_s;
    reg_addr_t              nxt_addr_s;
    data_t                  nxt_data_s;
    logic                   waw_hit_s;
    logic [NUM_REGS-1:0]    busy_s;

    logic [SC_W-1:0]        starve_cnt_r;
    logic                   wr_en_r;
    reg_addr_t              wr_addr_r;
    data_t                  wr_data_r;
    logic                   waw_err_r;

    wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_req  (push_req_s),
        .head_req  (head_s),
        .count     (count_s),
        .ent_valid (ent_valid_s),
        .ent_addr  (ent_addr_s)
    );

    // Readiness depends only on registered state, so producers never see a loop.
    assign q_nonempty_s = (count_s != {CNT_W{1'b0}});
    assign starve_hit_s = (starve_cnt_r == SC_W'(STARVE_LIMIT)) && q_nonempty_s;
    assign alu_rdy_s    = !rst && !starve_hit_s;
    assign ld_rdy_s     = !rst && (count_s < CNT_W'(LQ_DEPTH));
    assign alu_fire_s   = bus.alu_valid && alu_rdy_s;
    assign ld_fire_s    = bus.ld_valid && ld_rdy_s;
    assign ld_keep_s    = (bus.ld_addr != 3'd0);
    assign push_req_s   = '{addr: bus.ld_addr, data: bus.ld_data};

    // Write-port grant: ALU, then queue head, then a fast-path load.
    always_comb begin
        pop_s      = 1'b0;
        push_s     = 1'b0;
        nxt_en_s   = 1'b0;
        nxt_addr_s = wr_addr_r;
        nxt_data_s = wr_data_r;
        if (alu_fire_s) begin
            nxt_en_s   = (bus.alu_addr != 3'd0);
            nxt_addr_s = bus.alu_addr;
            nxt_data_s = bus.alu_data;
            push_s     = ld_fire_s && ld_keep_s;
        end else if (q_nonempty_s) begin
            pop_s      = 1'b1;
            nxt_en_s   = 1'b1;
            nxt_addr_s = head_s.addr;
            nxt_data_s = head_s.data;
            push_s     = ld_fire_s && ld_keep_s;
        end else if (ld_fire_s) begin
            nxt_en_s   = ld_keep_s;
            nxt_addr_s = bus.ld_addr;
            nxt_data_s = bus.ld_data;
        end else begin
            nxt_en_s   = 1'b0;
        end
    end

    // Scoreboard and WAW compare against every live queue slot.
    always_comb begin
        waw_hit_s = 1'b0;
        busy_s    = {NUM_REGS{1'b0}};
        for (int i = 0; i < LQ_DEPTH; i++) begin
            waw_hit_s = waw_hit_s | (ent_valid_s[i] && (ent_addr_s[i] == bus.alu_addr));
            busy_s    = busy_s | (ent_valid_s[i] ? reg_onehot(ent_addr_s[i]) : {NUM_REGS{1'b0}});
        end
        busy_s    = busy_s | (wr_en_r ? reg_onehot(wr_addr_r) : {NUM_REGS{1'b0}});
        busy_s[0] = 1'b0;
    end

    // Consecutive cycles a non-empty queue has been denied the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if (q_nonempty_s && !pop_s) begin
            starve_cnt_r <= (starve_cnt_r == SC_W'(STARVE_LIMIT)) ? starve_cnt_r
                                                                  : starve_cnt_r + SC_W'(1);
        end else begin
            starve_cnt_r <= {SC_W{1'b0}};
        end
    end

    // Registered write port and ordering-violation pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 3'd0;
            wr_data_r <= 8'h00;
            waw_err_r <= 1'b0;
        end else begin
            wr_en_r   <= nxt_en_s;
            wr_addr_r <= nxt_addr_s;
            wr_data_r <= nxt_data_s;
            waw_err_r <= alu_fire_s && waw_hit_s;
        end
    end

    assign bus.alu_ready = alu_rdy_s;
    assign bus.ld_ready  = ld_rdy_s;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.busy      = busy_s;
    assign bus.q_count   = count_s;
    assign bus.waw_err   = waw_err_r;

`ifdef WB_BYPASS_EN
    logic  byp_hit1_s;
    logic  byp_hit2_s;

    // Forward the write that the register file only shows next cycle.
    assign byp_hit1_s    = wr_en_r && (wr_addr_r == bus.byp_addr1) && (bus.byp_addr1 != 3'd0);
    assign byp_hit2_s    = wr_en_r && (wr_addr_r == bus.byp_addr2) && (bus.byp_addr2 != 3'd0);
    assign bus.byp_hit1  = byp_hit1_s;
    assign bus.byp_hit2  = byp_hit2_s;
    assign bus.byp_data1 = byp_hit1_s ? wr_data_r : 8'h00;
    assign bus.byp_data2 = byp_hit2_s ? wr_data_r : 8'h00;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;
    import mak8_pkg::*;

    localparam int LQ_DEPTH     = 4;
    localparam int STARVE_LIMIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    wb_arbiter_if #(.LQ_DEPTH(LQ_DEPTH)) bus ();

    wb_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: pending loads in arrival order plus the write stage.
    wb_req_t   mq[$];
    int        m_starve = 0;
    logic      m_en     = 1'b0;
    reg_addr_t m_addr   = 3'd0;
    data_t     m_data   = 8'h00;
    logic      m_waw    = 1'b0;

    function automatic bit m_alu_ready();
        return !rst && !(m_starve == STARVE_LIMIT && mq.size() > 0);
    endfunction

    function automatic bit m_ld_ready();
        return !rst && (mq.size() < LQ_DEPTH);
    endfunction

    function automatic logic [7:0] m_busy();
        logic [7:0] b;
        b = 8'h00;
        foreach (mq[i]) b[mq[i].addr] = 1'b1;
        if (m_en) b[m_addr] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit      a_acc;
        bit      l_acc;
        bit      popped;
        int      n0;
        wb_req_t e;
        if (rst) begin
            mq.delete();
            m_starve = 0;
            m_en     = 1'b0;
            m_addr   = 3'd0;
            m_data   = 8'h00;
            m_waw    = 1'b0;
        end else begin
            a_acc  = bus.alu_valid && m_alu_ready();
            l_acc  = bus.ld_valid && m_ld_ready();
            n0     = mq.size();
            popped = 1'b0;
            m_waw  = 1'b0;
            if (a_acc) foreach (mq[i]) if (mq[i].addr == bus.alu_addr) m_waw = 1'b1;
            if (a_acc) begin
                m_en   = (bus.alu_addr != 3'd0);
                m_addr = bus.alu_addr;
                m_data = bus.alu_data;
                if (l_acc && bus.ld_addr != 3'd0) mq.push_back('{addr: bus.ld_addr, data: bus.ld_data});
            end else if (n0 > 0) begin
                e      = mq.pop_front();
                popped = 1'b1;
                m_en   = 1'b1;
                m_addr = e.addr;
                m_data = e.data;
                if (l_acc && bus.ld_addr != 3'd0) mq.push_back('{addr: bus.ld_addr, data: bus.ld_data});
            end else if (l_acc) begin
                m_en   = (bus.ld_addr != 3'd0);
                m_addr = bus.ld_addr;
                m_data = bus.ld_data;
            end else begin
                m_en   = 1'b0;
            end
            if (n0 > 0 && !popped) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
            else m_starve = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle compare against the model, half a period after the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("alu_ready", bus.alu_ready, m_alu_ready());
            chk("ld_ready",  bus.ld_ready,  m_ld_ready());
            chk("wr_en",     bus.wr_en,     rst ? 1'b0 : m_en);
            if (rst || m_en) begin
                chk("wr_addr", bus.wr_addr, rst ? 3'd0 : m_addr);
                chk("wr_data", bus.wr_data, rst ? 8'h00 : m_data);
            end
            chk("busy",    bus.busy,    rst ? 8'h00 : m_busy());
            chk("q_count", bus.q_count, rst ? 32'd0 : 32'(mq.size()));
            chk("waw_err", bus.waw_err, rst ? 1'b0 : m_waw);
        end
    end

    task automatic put(input logic av, input reg_addr_t aa, input data_t ad,
                       input logic lv, input reg_addr_t la, input data_t ld);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_addr   = la;
        bus.ld_data   = ld;
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        put(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        idle();
        cyc(); cyc();
        chk("rst_wr_en",     bus.wr_en,     1'b0);
        chk("rst_busy",      bus.busy,      8'h00);
        chk("rst_alu_ready", bus.alu_ready, 1'b0);
        chk("rst_ld_ready",  bus.ld_ready,  1'b0);
        rst = 1'b0;
        cyc();
        chk("post_ld_ready",  bus.ld_ready,  1'b1);
        chk("post_alu_ready", bus.alu_ready, 1'b1);
        chk("post_q_count",   bus.q_count,   32'd0);

        // ALU only
        put(1'b1, 3'd1, 8'hAA, 1'b0, 3'd0, 8'h00); cyc();
        chk("alu_wr_en", bus.wr_en, 1'b1);
        chk("alu_addr",  bus.wr_addr, 3'd1);
        chk("alu_data",  bus.wr_data, 8'hAA);

        // Collision: ALU wins, load queued one cycle
        put(1'b1, 3'd2, 8'h55, 1'b1, 3'd3, 8'hF0); cyc();
        chk("col_addr",  bus.wr_addr, 3'd2);
        chk("col_data",  bus.wr_data, 8'h55);
        chk("col_q",     bus.q_count, 32'd1);
        chk("col_busy",  bus.busy,    8'h0C);
        idle(); cyc();
        chk("col_ld_addr", bus.wr_addr, 3'd3);
        chk("col_ld_data", bus.wr_data, 8'hF0);
        cyc();
        chk("col_busy3", bus.busy[3], 1'b0);

        // Fast path load
        put(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h99); cyc();
        chk("fast_addr", bus.wr_addr, 3'd3);
        chk("fast_data", bus.wr_data, 8'h99);
        chk("fast_q",    bus.q_count, 32'd0);
        idle(); cyc();

        // Starvation
        put(1'b1, 3'd5, 8'h01, 1'b1, 3'd4, 8'h0F); cyc();
        chk("stv_q", bus.q_count, 32'd1);
        put(1'b1, 3'd6, 8'h02, 1'b0, 3'd0, 8'h00); cyc();
        put(1'b1, 3'd7, 8'h03, 1'b0, 3'd0, 8'h00); cyc();
        chk("stv_rdy_hi", bus.alu_ready, 1'b1);
        put(1'b1, 3'd5, 8'h04, 1'b0, 3'd0, 8'h00); cyc();
        chk("stv_rdy_lo", bus.alu_ready, 1'b0);
        put(1'b1, 3'd6, 8'h05, 1'b0, 3'd0, 8'h00); cyc();
        chk("stv_ld_addr", bus.wr_addr, 3'd4);
        chk("stv_ld_data", bus.wr_data, 8'h0F);
        chk("stv_rdy_back", bus.alu_ready, 1'b1);
        cyc();
        chk("stv_alu_data", bus.wr_data, 8'h05);
        idle(); cyc();

        // Full queue under a continuous ALU stream
        put(1'b1, 3'd1, 8'h10, 1'b1, 3'd2, 8'h20); cyc();
        put(1'b1, 3'd1, 8'h11, 1'b1, 3'd3, 8'h21); cyc();
        put(1'b1, 3'd1, 8'h12, 1'b1, 3'd4, 8'h22); cyc();
        put(1'b1, 3'd1, 8'h13, 1'b1, 3'd5, 8'h23); cyc();
        chk("full_q",      bus.q_count,  32'd4);
        chk("full_ld_rdy", bus.ld_ready, 1'b0);
        put(1'b1, 3'd1, 8'h14, 1'b1, 3'd6, 8'h24); cyc();
        chk("full_q_held", bus.q_count, 32'd3);
        chk("full_head",   bus.wr_data, 8'h20);
        cyc();
        chk("full_q_refill", bus.q_count, 32'd4);
        chk("full_alu",      bus.wr_data, 8'h14);
        idle();
        for (int i = 0; i < 6; i++) cyc();
        chk("full_drained", bus.q_count, 32'd0);

        // R0 writes
        put(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 8'h42); cyc();
        chk("r0_wr_en", bus.wr_en,   1'b0);
        chk("r0_busy",  bus.busy,    8'h00);
        chk("r0_q",     bus.q_count, 32'd0);

        // WAW pulse
        put(1'b1, 3'd1, 8'h30, 1'b1, 3'd6, 8'h66); cyc();
        put(1'b1, 3'd6, 8'h77, 1'b0, 3'd0, 8'h00); cyc();
        chk("waw_pulse", bus.waw_err, 1'b1);
        chk("waw_data",  bus.wr_data, 8'h77);
        idle(); cyc();
        chk("waw_clear", bus.waw_err, 1'b0);
        chk("waw_ld",    bus.wr_data, 8'h66);
        cyc();

        // Reset mid-operation drops the queued load
        put(1'b1, 3'd2, 8'h01, 1'b1, 3'd3, 8'h02); cyc();
        idle();
        rst = 1'b1;
        cyc();
        chk("mrst_q",    bus.q_count, 32'd0);
        chk("mrst_busy", bus.busy,    8'h00);
        rst = 1'b0;
        cyc();
        chk("mrst_no_wr", bus.wr_en, 1'b0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
